// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, bus destination codes and the
// writeback FSM state encoding.
package cpu_pkg;

    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_SHRA = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_XOR  = 5'b10010;
    localparam logic [4:0] OP_NOR  = 5'b10011;
    localparam logic [4:0] OP_NOT  = 5'b10100;

    localparam logic [1:0] DEST_GPR = 2'b00;
    localparam logic [1:0] DEST_LO  = 2'b01;
    localparam logic [1:0] DEST_HI  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BEAT_LO = 2'b01,
        ST_BEAT_HI = 2'b10,
        ST_FIN     = 2'b11
    } wb_state_t;

endpackage

// File: rtl/z_reg64.sv
// Load-enabled Z register with asynchronous active-low clear.
module z_reg64 #(
    parameter int W = 64
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) q <= '0;
        else if (load) q <= d;
    end

endmodule

// File: rtl/alu_result_writeback.sv
// Captures the 64-bit ALU result and streams it onto the 32-bit bus in one
// beat (general register) or two beats (LO then HI for mul/div).
// Bus handshake: a beat is offered while bus_req=1 with bus_data/bus_dest
// held stable; it is consumed on any rising edge where bus_grant=1.
module alu_result_writeback
    import cpu_pkg::*;
#(
    parameter int         DATA_W = 32,
    parameter logic [4:0] NOP_OP = OP_NOP,
    parameter logic [4:0] MUL_OP = OP_MUL,
    parameter logic [4:0] DIV_OP = OP_DIV
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [2*DATA_W-1:0] alu_c,
    input  logic [4:0]          opcode,
    input  logic                capture,
    output logic                bus_req,
    input  logic                bus_grant,
    output logic [DATA_W-1:0]   bus_data,
    output logic [1:0]          bus_dest,
    output logic                busy,
    output logic                done,
    output logic                capture_drop,
    output logic                flag_zero,
    output logic                flag_neg,
    output logic [DATA_W-1:0]   zhi,
    output logic [DATA_W-1:0]   zlo,
    output wb_state_t           fsm_state
);

    wb_state_t           state;
    logic [4:0]          op_q;
    logic [2*DATA_W-1:0] z_q;
    logic                accept;
    logic                two_beat_in;
    logic                two_beat;

    assign accept      = (state == ST_IDLE) && capture;
    assign two_beat_in = (opcode == MUL_OP) || (opcode == DIV_OP);
    assign two_beat    = (op_q == MUL_OP) || (op_q == DIV_OP);
    assign zhi         = z_q[2*DATA_W-1:DATA_W];
    assign zlo         = z_q[DATA_W-1:0];
    assign fsm_state   = state;

    z_reg64 #(.W(2*DATA_W)) u_z_reg (
        .clock (clock),
        .clear (clear),
        .load  (accept),
        .d     (alu_c),
        .q     (z_q)
    );

    // Flags look at the full 64 bits only for two-beat results.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            op_q      <= '0;
            flag_zero <= 1'b0;
            flag_neg  <= 1'b0;
        end else if (accept) begin
            op_q      <= opcode;
            flag_zero <= two_beat_in ? (alu_c == '0) : (alu_c[DATA_W-1:0] == '0);
            flag_neg  <= two_beat_in ? alu_c[2*DATA_W-1] : alu_c[DATA_W-1];
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state        <= ST_IDLE;
            bus_req      <= 1'b0;
            bus_data     <= '0;
            bus_dest     <= DEST_GPR;
            busy         <= 1'b0;
            done         <= 1'b0;
            capture_drop <= 1'b0;
        end else begin
            done         <= 1'b0;
            capture_drop <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (capture) begin
                        busy <= 1'b1;
                        if (opcode == NOP_OP) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end else begin
                            state    <= ST_BEAT_LO;
                            bus_req  <= 1'b1;
                            bus_data <= alu_c[DATA_W-1:0];
                            bus_dest <= two_beat_in ? DEST_LO : DEST_GPR;
                        end
                    end
                end
                ST_BEAT_LO: begin
                    capture_drop <= capture;
                    if (bus_grant) begin
                        if (two_beat) begin
                            state    <= ST_BEAT_HI;
                            bus_data <= zhi;
                            bus_dest <= DEST_HI;
                        end else begin
                            state    <= ST_FIN;
                            bus_req  <= 1'b0;
                            bus_data <= '0;
                            bus_dest <= DEST_GPR;
                            done     <= 1'b1;
                        end
                    end
                end
                ST_BEAT_HI: begin
                    capture_drop <= capture;
                    if (bus_grant) begin
                        state    <= ST_FIN;
                        bus_req  <= 1'b0;
                        bus_data <= '0;
                        bus_dest <= DEST_GPR;
                        done     <= 1'b1;
                    end
                end
                ST_FIN: begin
                    capture_drop <= capture;
                    state        <= ST_IDLE;
                    busy         <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    bus_req  <= 1'b0;
                    bus_data <= '0;
                    bus_dest <= DEST_GPR;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_writeback.sv
// Directed bench for alu_result_writeback: expected bus beats are queued at
// capture time and checked by an independent monitor as they are granted.
module tb_alu_result_writeback;
    import cpu_pkg::*;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [63:0] alu_c = '0;
    logic [4:0]  opcode = '0;
    logic        capture = 1'b0;
    logic        bus_grant = 1'b0;
    logic        bus_req, busy, done, capture_drop, flag_zero, flag_neg;
    logic [31:0] bus_data, zhi, zlo;
    logic [1:0]  bus_dest;
    wb_state_t   fsm_state;

    logic [33:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clock = ~clock;

    alu_result_writeback dut (
        .clock        (clock),
        .clear        (clear),
        .alu_c        (alu_c),
        .opcode       (opcode),
        .capture      (capture),
        .bus_req      (bus_req),
        .bus_grant    (bus_grant),
        .bus_data     (bus_data),
        .bus_dest     (bus_dest),
        .busy         (busy),
        .done         (done),
        .capture_drop (capture_drop),
        .flag_zero    (flag_zero),
        .flag_neg     (flag_neg),
        .zhi          (zhi),
        .zlo          (zlo),
        .fsm_state    (fsm_state)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Beats are consumed on the next rising edge; inputs change only at posedge+1.
    always @(negedge clock) begin
        if (clear && bus_req && bus_grant) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_beat: got dest=%0h data=%0h expected none", bus_dest, bus_data);
            end else begin
                chk("beat", {30'd0, bus_dest, bus_data}, {30'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic push_beats(input logic [4:0] op, input logic [63:0] c);
        if (op == 5'b10000 || op == 5'b01111) begin
            exp_q.push_back({2'b01, c[31:0]});
            exp_q.push_back({2'b10, c[63:32]});
        end else if (op != 5'b11010) begin
            exp_q.push_back({2'b00, c[31:0]});
        end
    endtask

    // Returns after capture edge N, at N+1ns.
    task automatic do_capture(input logic [4:0] op, input logic [63:0] c);
        @(posedge clock); #1;
        capture = 1'b1;
        opcode  = op;
        alu_c   = c;
        push_beats(op, c);
        @(posedge clock); #1;
        capture = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_cycles);
        int cyc = 0;
        bit got = 0;
        while (cyc < 20 && !got) begin
            @(negedge clock);
            cyc++;
            if (done) got = 1;
        end
        chk(name, got ? 64'(cyc) : 64'd999, 64'(exp_cycles));
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_bus_req", {63'd0, bus_req}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_z", {zhi, zlo}, 64'd0);
        chk("rst_flags", {62'd0, flag_zero, flag_neg}, 64'd0);
        @(posedge clock); #1;
        clear = 1'b1;

        // Add, grant tied high
        bus_grant = 1'b1;
        do_capture(5'b00011, 64'h0000_0000_0000_0005);
        wait_done("add_latency", 2);
        chk("add_flags", {62'd0, flag_zero, flag_neg}, 64'd0);
        @(negedge clock);
        chk("add_idle_done", {62'd0, busy, done}, 64'd0);

        // Mul two beats, grant high
        do_capture(5'b10000, 64'hFFFF_FFFF_8000_0000);
        wait_done("mul_latency", 3);
        chk("mul_flags", {62'd0, flag_zero, flag_neg}, 64'd1);

        // Div with 4 stalled edges
        bus_grant = 1'b0;
        do_capture(5'b01111, 64'h0000_0001_0000_0003);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("stall_hold", {29'd0, bus_req, bus_dest, bus_data}, {29'd0, 1'b1, 2'b01, 32'h3});
        end
        @(posedge clock); #1;
        bus_grant = 1'b1;
        wait_done("div_latency", 3);
        chk("div_flags", {62'd0, flag_zero, flag_neg}, 64'd0);

        // NOP with zero result; capture held into FIN is dropped
        @(posedge clock); #1;
        capture = 1'b1;
        opcode  = 5'b11010;
        alu_c   = 64'd0;
        @(posedge clock); #1;
        alu_c = 64'h77;
        @(negedge clock);
        chk("nop_done", {63'd0, done}, 64'd1);
        @(posedge clock); #1;
        capture = 1'b0;
        @(negedge clock);
        chk("fin_drop", {63'd0, capture_drop}, 64'd1);
        chk("nop_flags", {62'd0, flag_zero, flag_neg}, 64'd2);
        chk("nop_z", {zhi, zlo}, 64'd0);
        chk("nop_idle", {63'd0, busy}, 64'd0);

        // Capture while in BEAT_LO
        bus_grant = 1'b0;
        do_capture(5'b00011, 64'h0000_0000_1234_5678);
        capture = 1'b1;
        alu_c   = 64'hAA;
        @(posedge clock); #1;
        capture = 1'b0;
        @(negedge clock);
        chk("busy_drop", {63'd0, capture_drop}, 64'd1);
        chk("busy_zlo", {32'd0, zlo}, 64'h1234_5678);
        @(negedge clock);
        chk("drop_pulse_end", {63'd0, capture_drop}, 64'd0);
        @(posedge clock); #1;
        bus_grant = 1'b1;
        wait_done("busy_latency", 2);

        // Asynchronous reset during BEAT_HI
        bus_grant = 1'b0;
        do_capture(5'b10000, 64'h1111_2222_3333_4444);
        bus_grant = 1'b1;
        @(posedge clock); #1;
        bus_grant = 1'b0;
        #1;
        chk("pre_rst_hi", {29'd0, bus_req, bus_dest, bus_data}, {29'd0, 1'b1, 2'b10, 32'h1111_2222});
        clear = 1'b0;
        #1;
        chk("arst_bus_req", {63'd0, bus_req}, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_z", {zhi, zlo}, 64'd0);
        chk("arst_state", {62'd0, fsm_state}, 64'd0);
        exp_q.delete();
        @(posedge clock); #1;
        clear = 1'b1;

        // Recovery: single-beat with low half zero, high half nonzero
        bus_grant = 1'b1;
        do_capture(5'b00100, 64'h8000_0000_0000_0000);
        wait_done("post_rst_latency", 2);
        chk("post_rst_flags", {62'd0, flag_zero, flag_neg}, 64'd2);
        chk("post_rst_zhi", {32'd0, zhi}, 64'h8000_0000);

        repeat (2) @(negedge clock);
        chk("leftover_beats", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_result_writeback.md
Name: alu_result_writeback

Overview:
- Downstream stage of the ALU. Captures the 64-bit ALU result C (the Z register) on a strobe and transfers it onto the 32-bit datapath bus via a request/grant handshake.
- Single-word results (add, sub, logic, shifts, rotates): one beat to the general destination.
- mul/div: two beats, low half to LO, then high half to HI.
- Also registers zero/negative flags for later branch logic.

Parameters:
- DATA_W, 32, bus word width; the captured result is 2*DATA_W wide.
- NOP_OP, 5'b11010, opcode that is captured but produces no bus beats.
- MUL_OP, 5'b10000, two-beat opcode.
- DIV_OP, 5'b01111, two-beat opcode.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous active-low reset.
- alu_c  in  64  ALU result C.
- opcode  in  5  opcode accompanying alu_c; sampled with capture.
- capture  in  1  Zin strobe; latches alu_c/opcode when idle.
- bus_req  out  1  a beat is pending on bus_data.
- bus_grant  in  1  bus owner accepts the current beat this cycle.
- bus_data  out  32  beat payload.
- bus_dest  out  2  00 = general register, 01 = LO, 10 = HI, 11 = unused.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the final beat, or after a NOP capture.
- capture_drop  out  1  one-cycle pulse when capture arrives while busy.
- flag_zero  out  1  result zero.
- flag_neg  out  1  result negative.
- zhi  out  32  Z register high half (observability).
- zlo  out  32  Z register low half (observability).

Behaviour:
- Reset (clear=0, asynchronous, any state): state=IDLE. All outputs 0: bus_req, bus_data, bus_dest, busy, done, capture_drop, flags, zhi, zlo. A transfer in progress is abandoned and no further beats are issued.
- States: IDLE, BEAT_LO, BEAT_HI, FIN.
- IDLE, capture=1 at edge N:
  - zhi/zlo <= alu_c. Latch opcode.
  - Two-beat flag = (opcode==MUL_OP or DIV_OP).
  - flag_zero <= two-beat ? (alu_c==0) : (alu_c[31:0]==0).
  - flag_neg <= two-beat ? alu_c[63] : alu_c[31].
  - Next state: FIN if opcode==NOP_OP, otherwise BEAT_LO.
- BEAT_LO:
  - bus_req=1, bus_data=zlo, bus_dest = two-beat ? 01 : 00.
  - First beat is visible in cycle N+1.
  - On an edge with bus_grant=1: go to BEAT_HI if two-beat, else FIN. Without grant, hold, with bus_data and bus_dest stable.
- BEAT_HI:
  - bus_req=1, bus_data=zhi, bus_dest=10.
  - On grant, go to FIN.
- FIN: done=1 and bus_req=0 for exactly one cycle; next state IDLE. busy stays 1 in FIN.
- Best-case latency, capture edge to done:
  - single-beat: 2 cycles (grant held high);
  - two-beat: 3 cycles;
  - NOP: 1 cycle.
- While bus_req=0: bus_data and bus_dest are driven 0. bus_grant is ignored.
- capture while busy (including FIN): ignored, Z register and flags unchanged, capture_drop pulses in the next cycle.
- capture and bus_grant in the same cycle while busy: the grant is honoured and the capture is dropped.
- zhi, zlo and flags hold their values until the next accepted capture.
- Opcodes outside the defined set are treated as single-beat.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams: nop, add, sub, mul, div, shr, shl, shra, ror, rol, and, or, neg, xor, nor, not;
  - bus_dest encodings: DEST_GPR, DEST_LO, DEST_HI;
  - FSM state encoding.
- One natural sub-module: z_reg64, the 64-bit load-enabled register with async active-low clear, reused for Z capture. FSM and flag logic stay in the top module.

Test Plan:
- Add result, grant tied high: capture with opcode=00011, alu_c=64'h0000_0000_0000_0005 -> at N+1 bus_req=1, bus_data=5, bus_dest=00. At N+2 done=1. flag_zero=0, flag_neg=0.
- Mul two-beat: opcode=10000, alu_c=64'hFFFF_FFFF_8000_0000, grant high -> beat 1 bus_data=8000_0000 with dest 01. Beat 2 bus_data=FFFF_FFFF with dest 10. done at N+3. flag_neg=1.
- Grant stall: div opcode=01111, alu_c=64'h0000_0001_0000_0003, grant low for 4 cycles -> bus_req=1 with bus_data=3 and dest 01 held for all 4 cycles. After grant: HI beat with bus_data=1, then done.
- NOP and zero flag: opcode=11010, alu_c=0 -> no bus_req ever, done at N+1, flag_zero=1.
- Capture while busy: second capture (alu_c=64'hAA) during BEAT_LO -> capture_drop pulse, zlo unchanged, only the original beat(s) issued.
- Reset mid-operation: clear=0 asynchronously during BEAT_HI -> bus_req, busy, zhi and zlo go 0 immediately with no clock edge. After release, the block is IDLE and the next capture works normally.
